// File: rtl/alu_dispatch_arbiter_pkg.sv
// Shared ALU command/response types plus the bank-tracker state enum and sizing constants.
package alu_dispatch_arbiter_pkg;

  localparam int unsigned NUM_ALU_BANKS  = 4;
  localparam int unsigned NUM_REQUESTERS = 4;

  typedef enum logic [2:0] {
    NOP        = 3'd0,
    ADD        = 3'd1,
    SUBTRACT   = 3'd2,
    MULTIPLY   = 3'd3,
    AND        = 3'd4,
    OR         = 3'd5,
    XOR        = 3'd6,
    SHIFT_LEFT = 3'd7
  } command_names_t;

  typedef enum logic [1:0] {
    NO_RESPONSE = 2'd0,
    SUCCESS     = 2'd1,
    OVERFLOW    = 2'd2,
    INVALID     = 2'd3
  } response_names_t;

  typedef struct packed {
    command_names_t command;
    logic [31:0]    data1;
    logic [31:0]    data2;
  } input_packet_t;

  typedef struct packed {
    response_names_t response;
    logic [31:0]     data;
  } output_packet_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StBusy  = 2'd2
  } bank_state_t;

  // One-hot round-robin pick; the requester at ptr has the highest priority.
  function automatic logic [NUM_REQUESTERS-1:0] rr_pick(
    input logic [NUM_REQUESTERS-1:0] eligible,
    input logic [1:0]                ptr
  );
    logic [NUM_REQUESTERS-1:0] grant;
    logic [1:0]                idx;
    grant = '0;
    for (int k = NUM_REQUESTERS - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (eligible[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/alu_bank_tracker.sv
// One ALU bank: IDLE -> ISSUE -> BUSY -> IDLE with captured packet and owner.
// Optional BUSY no-response watchdog enabled by macro ALU_TIMEOUT_EN.
module alu_bank_tracker
  import alu_dispatch_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic           i_clock,
  input  logic           i_reset,
  input  logic           i_capture,
  input  input_packet_t  i_packet,
  input  logic [1:0]     i_owner,
  input  output_packet_t i_alu_result,
  output logic           o_idle,
  output input_packet_t  o_alu_input,
  output logic           o_done,
  output logic           o_timeout,
  output logic [1:0]     o_owner
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  bank_state_t   r_state;
  bank_state_t   w_state_next;
  input_packet_t r_packet;
  logic [1:0]    r_owner;
  logic          w_has_response;
  logic          w_expired;

  assign w_has_response = (i_alu_result.response != NO_RESPONSE);

`ifdef ALU_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  logic [CntW-1:0] r_busy_cnt;

  // Response in the expiry cycle wins, so expiry is masked by a response.
  assign w_expired = (r_state == StBusy) && !w_has_response &&
                     (r_busy_cnt == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clock) begin
    if (!i_reset || (r_state != StBusy)) begin
      r_busy_cnt <= '0;
    end else if (!w_expired) begin
      r_busy_cnt <= r_busy_cnt + CntW'(1);
    end
  end
`else
  assign w_expired = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    o_done       = 1'b0;
    o_alu_input  = '{command: NOP, data1: r_packet.data1, data2: r_packet.data2};
    unique case (r_state)
      StIdle: begin
        if (i_capture) w_state_next = StIssue;
      end
      StIssue: begin
        o_alu_input  = r_packet;
        w_state_next = StBusy;
      end
      StBusy: begin
        if (w_has_response) begin
          o_done       = 1'b1;
          w_state_next = StIdle;
        end else if (w_expired) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state  <= StIdle;
      r_packet <= '0;
      r_owner  <= '0;
    end else begin
      r_state <= w_state_next;
      if (i_capture && (r_state == StIdle)) begin
        r_packet <= i_packet;
        r_owner  <= i_owner;
      end
    end
  end

  assign o_idle    = (r_state == StIdle);
  assign o_timeout = w_expired;
  assign o_owner   = r_owner;

endmodule

// File: rtl/alu_dispatch_arbiter.sv
// Round-robin dispatch of four requesters onto four ALU banks with per-owner response routing.
// Macro ALU_TIMEOUT_EN enables per-bank BUSY timeouts reported on o_timeout_flag.
module alu_dispatch_arbiter
  import alu_dispatch_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                                 i_clock,
  input  logic                                 i_reset,
  input  logic           [NUM_REQUESTERS-1:0]  i_req_valid,
  input  input_packet_t  [NUM_REQUESTERS-1:0]  i_req_packet,
  output logic           [NUM_REQUESTERS-1:0]  o_req_ready,
  output input_packet_t  [NUM_ALU_BANKS-1:0]   o_alu_input_packet,
  input  output_packet_t [NUM_ALU_BANKS-1:0]   i_alu_output_packet,
  output logic           [NUM_REQUESTERS-1:0]  o_rsp_valid,
  output output_packet_t [NUM_REQUESTERS-1:0]  o_rsp_packet,
  output logic           [NUM_REQUESTERS-1:0]  o_timeout_flag
);

  logic           [1:0]                r_rr_ptr;
  logic           [NUM_REQUESTERS-1:0] r_outstanding;
  logic           [NUM_REQUESTERS-1:0] r_rsp_valid;
  output_packet_t [NUM_REQUESTERS-1:0] r_rsp_packet;

  logic [NUM_REQUESTERS-1:0] w_eligible;
  logic [NUM_REQUESTERS-1:0] w_grant;
  logic [NUM_REQUESTERS-1:0] w_release;
  logic [NUM_REQUESTERS-1:0] w_outstanding_next;
  logic [NUM_ALU_BANKS-1:0]  w_bank_idle;
  logic [NUM_ALU_BANKS-1:0]  w_bank_done;
  logic [NUM_ALU_BANKS-1:0]  w_bank_timeout;
  logic [NUM_ALU_BANKS-1:0]  w_capture;
  logic [1:0]                w_bank_owner [NUM_ALU_BANKS];
  logic [1:0]                w_grant_id;
  logic [1:0]                w_bank_sel;
  input_packet_t             w_grant_packet;

  always_comb begin
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      w_eligible[i] = i_req_valid[i] && (i_req_packet[i].command != NOP) && !r_outstanding[i];
    end
    w_grant = (|w_bank_idle) ? rr_pick(w_eligible, r_rr_ptr) : '0;
  end

  // Encode the winner and pick the lowest-index idle bank.
  always_comb begin
    w_grant_id = '0;
    for (int i = NUM_REQUESTERS - 1; i >= 0; i--) begin
      if (w_grant[i]) w_grant_id = 2'(i);
    end
    w_bank_sel = '0;
    for (int b = NUM_ALU_BANKS - 1; b >= 0; b--) begin
      if (w_bank_idle[b]) w_bank_sel = 2'(b);
    end
    w_capture = '0;
    if (|w_grant) w_capture[w_bank_sel] = 1'b1;
    w_grant_packet = i_req_packet[w_grant_id];
  end

  always_comb begin
    w_release = '0;
    for (int b = 0; b < NUM_ALU_BANKS; b++) begin
      if (w_bank_done[b] || w_bank_timeout[b]) w_release[w_bank_owner[b]] = 1'b1;
    end
    w_outstanding_next = (r_outstanding | w_grant) & ~w_release;
  end

  for (genvar b = 0; b < NUM_ALU_BANKS; b++) begin : g_bank
    alu_bank_tracker #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_tracker (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_capture   (w_capture[b]),
      .i_packet    (w_grant_packet),
      .i_owner     (w_grant_id),
      .i_alu_result(i_alu_output_packet[b]),
      .o_idle      (w_bank_idle[b]),
      .o_alu_input (o_alu_input_packet[b]),
      .o_done      (w_bank_done[b]),
      .o_timeout   (w_bank_timeout[b]),
      .o_owner     (w_bank_owner[b])
    );
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_rr_ptr      <= '0;
      r_outstanding <= '0;
      r_rsp_valid   <= '0;
      r_rsp_packet  <= '0;
    end else begin
      r_rsp_valid   <= '0;
      r_outstanding <= w_outstanding_next;
      if (|w_grant) r_rr_ptr <= w_grant_id + 2'd1;
      for (int b = 0; b < NUM_ALU_BANKS; b++) begin
        if (w_bank_done[b]) begin
          r_rsp_valid[w_bank_owner[b]]  <= 1'b1;
          r_rsp_packet[w_bank_owner[b]] <= i_alu_output_packet[b];
        end
      end
    end
  end

`ifdef ALU_TIMEOUT_EN
  logic [NUM_REQUESTERS-1:0] r_timeout_flag;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_timeout_flag <= '0;
    end else begin
      r_timeout_flag <= '0;
      for (int b = 0; b < NUM_ALU_BANKS; b++) begin
        if (w_bank_timeout[b]) r_timeout_flag[w_bank_owner[b]] <= 1'b1;
      end
    end
  end

  assign o_timeout_flag = r_timeout_flag;
`else
  assign o_timeout_flag = '0;
`endif

  assign o_req_ready  = w_grant;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_packet = r_rsp_packet;

endmodule
